// File: rtl/hazard_ctrl.sv
// Load-use hazard controller: scoreboard of in-flight destinations, bubble/stall
// generation, and a controller FSM. Optional stall watchdog enabled by HAZARD_WDOG_EN.
module hazard_ctrl #(
   parameter int SB_DEPTH = 2,
   parameter int WDOG_MAX = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       exp_read1,
   input  logic [4:0] exp_addr1,
   input  logic       exp_read2,
   input  logic [4:0] exp_addr2,
   input  logic [4:0] tar_addr,
   input  logic       tar_wreg,
   input  logic       stop,
   output logic       bbl,
   output logic [1:0] state_o,
   output logic       wdog_o
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      HAZ    = 2'd1,
      EXWAIT = 2'd2
   } state_t;

   logic [SB_DEPTH-1:0] sb_valid;
   logic [4:0]          sb_addr [SB_DEPTH];
   logic                match1;
   logic                match2;
   logic                hit1;
   logic                hit2;
   state_t              state_q;

   always_comb begin
      match1 = 1'b0;
      match2 = 1'b0;
      for (int i = 0; i < SB_DEPTH; i++) begin
         if (sb_valid[i] && sb_addr[i] == exp_addr1) match1 = 1'b1;
         if (sb_valid[i] && sb_addr[i] == exp_addr2) match2 = 1'b1;
      end
   end

   // r0 is hardwired zero, so it can never be a true dependency
   assign hit1 = exp_read1 && (exp_addr1 != 5'd0) && match1;
   assign hit2 = exp_read2 && (exp_addr2 != 5'd0) && match2;
   assign bbl  = hit1 || hit2 || stop;

   // Entry 0 follows EX, entry 1 follows MEM; on a multi-cycle stop EX holds and MEM drains
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sb_valid <= '0;
         for (int i = 0; i < SB_DEPTH; i++) sb_addr[i] <= 5'd0;
      end else begin
         if (!stop) begin
            sb_valid[0] <= bbl ? 1'b0 : (tar_wreg && tar_addr != 5'd0);
            sb_addr[0]  <= tar_addr;
         end
         for (int i = 1; i < SB_DEPTH; i++) begin
            if (stop && i == 1) begin
               sb_valid[i] <= 1'b0;
            end else begin
               sb_valid[i] <= sb_valid[i-1];
               sb_addr[i]  <= sb_addr[i-1];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= RUN;
      end else if (stop) begin
         state_q <= EXWAIT;
      end else if (hit1 || hit2) begin
         state_q <= HAZ;
      end else begin
         state_q <= RUN;
      end
   end

   assign state_o = state_q;

`ifdef HAZARD_WDOG_EN
   localparam int CW = (WDOG_MAX < 1) ? 1 : $clog2(WDOG_MAX + 1);

   logic [CW-1:0] stall_cnt;
   logic          wdog_q;

   // Counts consecutive bubble cycles; the flag is sticky until reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
         wdog_q    <= 1'b0;
      end else if (bbl) begin
         if (stall_cnt == CW'(WDOG_MAX)) begin
            wdog_q <= 1'b1;
         end else begin
            stall_cnt <= stall_cnt + 1'b1;
         end
      end else begin
         stall_cnt <= '0;
      end
   end

   assign wdog_o = wdog_q;
`else
   assign wdog_o = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed hazard scenarios plus random traffic against a
// pipeline-occupancy model of in-flight destination registers.
module tb_hazard_ctrl;

   localparam int WDOG_MAX = 255;
`ifdef HAZARD_WDOG_EN
   localparam bit WD_EN = 1'b1;
`else
   localparam bit WD_EN = 1'b0;
`endif

   logic       clk;
   logic       rst;
   logic       exp_read1;
   logic [4:0] exp_addr1;
   logic       exp_read2;
   logic [4:0] exp_addr2;
   logic [4:0] tar_addr;
   logic       tar_wreg;
   logic       stop;
   logic       bbl;
   logic [1:0] state_o;
   logic       wdog_o;

   int errors = 0;
   int checks = 0;
   int stallSeen;

   // Model: destination register held by EX (pipe[0]) and MEM (pipe[1]); 0 = nothing pending
   int pipe [2];
   int mState;
   int mCnt;
   bit mWdog;

   hazard_ctrl #(.SB_DEPTH(2), .WDOG_MAX(WDOG_MAX)) dut (
      .clk(clk),
      .rst(rst),
      .exp_read1(exp_read1),
      .exp_addr1(exp_addr1),
      .exp_read2(exp_read2),
      .exp_addr2(exp_addr2),
      .tar_addr(tar_addr),
      .tar_wreg(tar_wreg),
      .stop(stop),
      .bbl(bbl),
      .state_o(state_o),
      .wdog_o(wdog_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL timeout reached");
      $fatal(1, "[TB] timeout");
   end

   function automatic bit pending(input logic [4:0] a);
      return (a != 5'd0) && (pipe[0] == int'(a) || pipe[1] == int'(a));
   endfunction

   function automatic bit modelHit();
      return (exp_read1 && pending(exp_addr1)) || (exp_read2 && pending(exp_addr2));
   endfunction

   function automatic bit modelBbl();
      return modelHit() || stop;
   endfunction

   task automatic modelReset();
      pipe[0] = 0;
      pipe[1] = 0;
      mState  = 0;
      mCnt    = 0;
      mWdog   = 1'b0;
   endtask

   task automatic checkOutput(input string tag);
      logic expBbl;
      logic [1:0] expState;
      logic expWdog;
      expBbl   = (rst === 1'b0) ? stop : modelBbl();
      expState = 2'(mState);
      expWdog  = WD_EN ? mWdog : 1'b0;
      checks++;
      assert (bbl === expBbl) else begin
         errors++;
         $error("[TB] FAIL %s bbl got %0b want %0b", tag, bbl, expBbl);
      end
      checks++;
      assert (state_o === expState) else begin
         errors++;
         $error("[TB] FAIL %s state_o got %0d want %0d", tag, state_o, expState);
      end
      checks++;
      assert (wdog_o === expWdog) else begin
         errors++;
         $error("[TB] FAIL %s wdog_o got %0b want %0b", tag, wdog_o, expWdog);
      end
      if (bbl === 1'b1) stallSeen++;
   endtask

   task automatic applyStimulus(input string tag, input logic r1, input logic [4:0] a1,
                                input logic r2, input logic [4:0] a2,
                                input logic tw, input logic [4:0] ta, input logic st);
      exp_read1 = r1;
      exp_addr1 = a1;
      exp_read2 = r2;
      exp_addr2 = a2;
      tar_wreg  = tw;
      tar_addr  = ta;
      stop      = st;
      #1;
      checkOutput(tag);
   endtask

   // Advance one clock, updating the model from the inputs that were present at the edge
   task automatic advance();
      bit b;
      bit h;
      b = modelBbl();
      h = modelHit();
      if (stop) begin
         pipe[1] = 0;
      end else begin
         pipe[1] = pipe[0];
         pipe[0] = (!b && tar_wreg && tar_addr != 5'd0) ? int'(tar_addr) : 0;
      end
      mState = stop ? 2 : (h ? 1 : 0);
      if (b) begin
         if (mCnt == WDOG_MAX) mWdog = 1'b1;
         if (mCnt < WDOG_MAX) mCnt++;
      end else begin
         mCnt = 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic step(input string tag, input logic r1, input logic [4:0] a1,
                       input logic r2, input logic [4:0] a2,
                       input logic tw, input logic [4:0] ta, input logic st);
      applyStimulus(tag, r1, a1, r2, a2, tw, ta, st);
      advance();
   endtask

   task automatic expectStalls(input string tag, input int want);
      checks++;
      assert (stallSeen == want) else begin
         errors++;
         $error("[TB] FAIL %s stall cycles got %0d want %0d", tag, stallSeen, want);
      end
   endtask

   initial begin
      rst = 1'b0;
      modelReset();
      exp_read1 = 1'b0; exp_addr1 = 5'd0;
      exp_read2 = 1'b0; exp_addr2 = 5'd0;
      tar_wreg  = 1'b0; tar_addr  = 5'd0;
      stop      = 1'b0;
      #2;
      checkOutput("reset_idle");
      stop = 1'b1;
      #1;
      checkOutput("reset_stop");
      stop = 1'b0;
      #9;
      rst = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] EX-distance dependency on port 1");
      step("r5_write", 0, 0, 0, 0, 1, 5'd5, 0);
      stallSeen = 0;
      for (int i = 0; i < 3; i++) step("r5_read1", 1, 5'd5, 0, 0, 1, 5'd6, 0);
      expectStalls("r5_ex_stall", 2);
      step("r5_after", 0, 0, 0, 0, 0, 0, 0);

      $display("[TB] MEM-distance dependency on port 2");
      step("r5b_write", 0, 0, 0, 0, 1, 5'd5, 0);
      step("unrelated", 1, 5'd1, 0, 0, 1, 5'd2, 0);
      stallSeen = 0;
      for (int i = 0; i < 2; i++) step("r5_read2", 0, 0, 1, 5'd5, 0, 0, 0);
      expectStalls("r5_mem_stall", 1);

      $display("[TB] r0 never hazards");
      step("r0_write", 0, 0, 0, 0, 1, 5'd0, 0);
      stallSeen = 0;
      for (int i = 0; i < 2; i++) step("r0_read", 1, 5'd0, 1, 5'd0, 0, 0, 0);
      expectStalls("r0_stall", 0);

      $display("[TB] multi-cycle stop with r7 pending");
      step("r7_write", 0, 0, 0, 0, 1, 5'd7, 0);
      stallSeen = 0;
      for (int i = 0; i < 4; i++) step("stop_hold", 0, 0, 0, 0, 1, 5'd8, 1);
      expectStalls("stop_stall", 4);
      stallSeen = 0;
      for (int i = 0; i < 3; i++) step("r7_read", 1, 5'd7, 0, 0, 0, 0, 0);
      expectStalls("r7_held_stall", 2);

      $display("[TB] long stop for watchdog");
      for (int i = 0; i < 300; i++) step("wdog_stop", 0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) step("wdog_after", 0, 0, 0, 0, 0, 0, 0);

      $display("[TB] reset during a r9 stall");
      step("r9_write", 0, 0, 0, 0, 1, 5'd9, 0);
      applyStimulus("r9_stall", 1, 5'd9, 0, 0, 0, 0, 0);
      rst = 1'b0;
      modelReset();
      #1;
      checkOutput("r9_rst_low");
      rst = 1'b1;
      #1;
      checkOutput("r9_rst_rel");
      advance();
      step("r9_reread", 1, 5'd9, 0, 0, 0, 0, 0);

      $display("[TB] random traffic");
      for (int n = 0; n < 300; n++) begin
         step("random",
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
              1'($urandom_range(0, 7) == 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter SB_DEPTH, default 2, meaning scoreboard entries checked (EX, MEM; the write-back stage is covered by regfile write-through bypass).
REQ-002 SHALL have parameter WDOG_MAX, default 255, meaning consecutive stall cycles before the watchdog flag sets.
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 exp_read1  input  1  ID stage reads operand port 1.
REQ-006 exp_addr1  input  5  ID operand 1 register address.
REQ-007 exp_read2  input  1  ID stage reads operand port 2.
REQ-008 exp_addr2  input  5  ID operand 2 register address.
REQ-009 tar_addr  input  5  ID destination register address.
REQ-010 tar_wreg  input  1  ID instruction writes tar_addr.
REQ-011 stop  input  1  EX stage busy with a multi-cycle operation.
REQ-012 bbl  output  1  bubble: freeze PC and IF/ID, insert NOP into ID/EX.
REQ-013 state_o  output  2  controller state: 0 RUN, 1 HAZ, 2 EXWAIT.
REQ-014 wdog_o  output  1  sticky watchdog flag.

Function
REQ-015 Scoreboard entry i SHALL hold {valid, addr[4:0]}; entry 0 tracks EX, entry 1 tracks MEM.
REQ-016 Hit on port n SHALL be exp_readn && exp_addrn != 0 && any valid entry with addr == exp_addrn.
REQ-017 bbl SHALL be combinational: hit1 || hit2 || stop; no registered delay.
REQ-018 Per edge, if stop=1: entry 0 holds; entry 1 loads invalid; entries >=2 shift from i-1.
REQ-019 Per edge, if stop=0 and bbl=1: entry 0 loads invalid (inserted bubble); entries >=1 shift from i-1.
REQ-020 Per edge, if bbl=0: entry 0 loads {tar_wreg && tar_addr != 0, tar_addr}; entries >=1 shift from i-1.
REQ-021 Register 0 SHALL never create a hazard or a valid entry.
REQ-022 FSM next state: stop=1 -> EXWAIT (stop takes priority over hit); else hit -> HAZ; else RUN; all transitions are legal from every state.
REQ-023 state_o SHALL equal the registered FSM state, so it lags bbl by one cycle.
REQ-024 Stall counter SHALL reset to 0 on any cycle with bbl=0, increment on bbl=1, and saturate at WDOG_MAX.
REQ-025 wdog_o SHALL set on the edge where the counter equals WDOG_MAX with bbl=1, and stays set until reset.
REQ-026 A port may hit entries 0 and 1 at once; the stall lasts until neither matches (2 cycles for EX hit, 1 for MEM hit).

Reset
REQ-027 rst=0 SHALL immediately clear all entries to invalid, set FSM to RUN, clear the counter, clear wdog_o (bbl then follows only stop).
REQ-028 Reset asserted mid-stall SHALL drop hazard-driven bbl in the same cycle; the first edge after release operates per REQ-018..020.

Configuration
REQ-029 Macro HAZARD_WDOG_EN defined: counter and wdog_o are implemented per REQ-024/025.
REQ-030 HAZARD_WDOG_EN undefined: no counter logic; wdog_o is tied to 0; all other behaviour is unchanged.

Verification
REQ-031 ID writes r5, next ID reads r5 on port 1 -> bbl=1 for 2 cycles, then 0; state_o shows HAZ for 2 cycles.
REQ-032 ID writes r5, one unrelated instruction, then read r5 on port 2 -> bbl=1 for exactly 1 cycle.
REQ-033 Write r0, next reads r0 on both ports -> bbl stays 0.
REQ-034 stop=1 for 4 cycles with a pending r7 in entry 0 -> bbl=1 for 4 cycles; entry 0 stays r7; entry 1 invalid after the first edge; state_o=2.
REQ-035 stop held 300 cycles with HAZARD_WDOG_EN -> wdog_o rises after 255 stall cycles and stays 1 after stop drops; without the macro, wdog_o stays 0.
REQ-036 rst pulsed low during a HAZ stall on r9 -> bbl drops immediately, and a read of r9 after release does not stall.
